cache_tag_ctrl: RTL and testbench

CACHE_TAG_CTRL -- requirements
Module: cache_tag_ctrl

---
 rtl/cache_tag_ctrl.sv | 146 ++++++++++++++
 tb/tb_cache_tag_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_tag_ctrl.sv
// Tag lookup / refill controller for a 4-way, 8-set cache with 24-bit tags and 32-byte lines.
// Tag arrays live outside; this block owns valid bits, round-robin victim pointers and the handshakes.
module cache_tag_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_hit,
    output logic [1:0]  resp_way,
    output logic [2:0]  tag_raddr,
    input  logic [95:0] tag_rdata,
    output logic [2:0]  tag_waddr,
    output logic [3:0]  tag_wen,
    output logic [23:0] tag_wdata,
    output logic        refill_valid,
    input  logic        refill_ready,
    output logic [31:0] refill_addr,
    input  logic        refill_done,
    input  logic        inv_all
);

    localparam int unsigned WAYS   = 4;
    localparam int unsigned SETS   = 8;
    localparam int unsigned TAG_W  = 24;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned WAY_W  = 2;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, UPDATE, RESP
    } state_t;

    state_t                        state, state_nxt;
    logic [SETS-1:0][WAYS-1:0]     valid_q;
    logic [SETS-1:0][WAY_W-1:0]    ptr_q;
    logic [ADDR_W-1:0]             addr_q;
    logic [WAY_W-1:0]              victim_q;
    logic                          hit_q;
    logic [WAY_W-1:0]              way_q;
    logic                          rdy_en_q;

    logic [IDX_W-1:0]              idx_c;
    logic [TAG_W-1:0]              tag_c;
    logic                          hit_c;
    logic [WAY_W-1:0]              hit_way_c;
    logic                          free_c;
    logic [WAY_W-1:0]              free_way_c;
    logic                          req_fire_c;

    assign idx_c = addr_q[7:5];
    assign tag_c = addr_q[31:8];

    // Lowest matching way wins a hit; lowest invalid way is the preferred victim.
    always_comb begin
        hit_c      = 1'b0;
        hit_way_c  = '0;
        free_c     = 1'b0;
        free_way_c = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx_c][w] && (tag_rdata[w*TAG_W +: TAG_W] == tag_c)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
            if (!valid_q[idx_c][w]) begin
                free_c     = 1'b1;
                free_way_c = WAY_W'(w);
            end
        end
    end

    assign req_ready  = (state == IDLE) && !inv_all && rdy_en_q;
    assign req_fire_c = req_valid && req_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (req_fire_c)   state_nxt = LOOKUP;
            LOOKUP:      state_nxt = hit_c ? RESP : REFILL_REQ;
            REFILL_REQ:  if (refill_ready) state_nxt = REFILL_WAIT;
            REFILL_WAIT: if (refill_done)  state_nxt = UPDATE;
            UPDATE:      state_nxt = RESP;
            RESP:        if (resp_ready)   state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            valid_q  <= '0;
            ptr_q    <= '0;
            addr_q   <= '0;
            victim_q <= '0;
            hit_q    <= 1'b0;
            way_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            rdy_en_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (inv_all) begin
                        valid_q <= '0;
                    end else if (req_fire_c) begin
                        addr_q <= req_addr;
                    end
                end
                LOOKUP: begin
                    if (hit_c) begin
                        hit_q <= 1'b1;
                        way_q <= hit_way_c;
                    end else begin
                        hit_q <= 1'b0;
                        if (free_c) begin
                            victim_q <= free_way_c;
                        end else begin
                            victim_q      <= ptr_q[idx_c];
                            ptr_q[idx_c]  <= ptr_q[idx_c] + WAY_W'(1);
                        end
                    end
                end
                UPDATE: begin
                    valid_q[idx_c][victim_q] <= 1'b1;
                    hit_q                    <= 1'b0;
                    way_q                    <= victim_q;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode directly from registered state so reset clears them at once.
    assign resp_valid   = (state == RESP);
    assign resp_hit     = hit_q;
    assign resp_way     = way_q;
    assign tag_raddr    = idx_c;
    assign tag_waddr    = idx_c;
    assign tag_wdata    = tag_c;
    assign tag_wen      = (state == UPDATE) ? (WAYS'(1) << victim_q) : '0;
    assign refill_valid = (state == REFILL_REQ);
    assign refill_addr  = addr_q & ~ADDR_W'(32'h1F);

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Directed self-checking bench for cache_tag_ctrl with a behavioural tag-array and memory model.
module tb_cache_tag_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_hit;
    logic [1:0]  resp_way;
    logic [2:0]  tag_raddr;
    logic [95:0] tag_rdata;
    logic [2:0]  tag_waddr;
    logic [3:0]  tag_wen;
    logic [23:0] tag_wdata;
    logic        refill_valid;
    logic        refill_ready;
    logic [31:0] refill_addr;
    logic        refill_done;
    logic        inv_all;

    int asserts = 0;
    int fails   = 0;
    int wr_total = 0;

    logic [23:0] tmem [4][8];

    typedef struct {
        logic [31:0] raddr;
        logic        saw_refill;
        logic [3:0]  wen;
        logic [23:0] wdata;
        logic [2:0]  waddr;
        int          wen_cnt;
        logic        hit;
        logic [1:0]  way;
        int          resp_cyc;
        int          rv_cycles;
        int          resp_cycles;
        logic        unstable;
        logic        timeout;
    } txn_t;

    cache_tag_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_hit     (resp_hit),
        .resp_way     (resp_way),
        .tag_raddr    (tag_raddr),
        .tag_rdata    (tag_rdata),
        .tag_waddr    (tag_waddr),
        .tag_wen      (tag_wen),
        .tag_wdata    (tag_wdata),
        .refill_valid (refill_valid),
        .refill_ready (refill_ready),
        .refill_addr  (refill_addr),
        .refill_done  (refill_done),
        .inv_all      (inv_all)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tag_rdata = {tmem[3][tag_raddr], tmem[2][tag_raddr], tmem[1][tag_raddr], tmem[0][tag_raddr]};

    always @(posedge clk) begin
        for (int w = 0; w < 4; w++) if (tag_wen[w]) tmem[w][tag_waddr] <= tag_wdata;
        if (tag_wen != 4'b0) wr_total <= wr_total + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Runs one request to completion, recording what the controller showed on each cycle.
    task automatic do_req(input logic [31:0] a, input int rr_wait, input int rsp_wait, output txn_t r);
        int  n;
        int  rr_cnt;
        int  rs_cnt;
        int  wait_cnt;
        bit  refill_acc;
        bit  done_sent;
        bit  got;
        bit  done;
        r = '{default: '0};
        rr_cnt = 0; rs_cnt = 0; wait_cnt = 0;
        refill_acc = 0; done_sent = 0; got = 0; done = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            r.timeout = 1'b1;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            refill_done = 1'b0;
            if (refill_acc && !done_sent) begin
                if (wait_cnt >= 2) begin
                    refill_done = 1'b1;
                    done_sent   = 1;
                end
                wait_cnt++;
            end
            if (refill_valid) begin
                r.rv_cycles++;
                if (!r.saw_refill) begin
                    r.saw_refill = 1'b1;
                    r.raddr      = refill_addr;
                end else if (refill_addr !== r.raddr) begin
                    r.unstable = 1'b1;
                end
                if (rr_cnt >= rr_wait) begin
                    refill_ready = 1'b1;
                    refill_acc   = 1;
                end else begin
                    refill_ready = 1'b0;
                end
                rr_cnt++;
            end else begin
                refill_ready = 1'b0;
            end
            if (tag_wen != 4'b0) begin
                r.wen_cnt++;
                r.wen   = tag_wen;
                r.wdata = tag_wdata;
                r.waddr = tag_waddr;
            end
            if (resp_valid) begin
                r.resp_cycles++;
                if (!got) begin
                    got        = 1;
                    r.resp_cyc = cyc;
                    r.hit      = resp_hit;
                    r.way      = resp_way;
                end else if (resp_hit !== r.hit || resp_way !== r.way) begin
                    r.unstable = 1'b1;
                end
                if (rs_cnt >= rsp_wait) begin
                    resp_ready = 1'b1;
                    @(negedge clk);
                    resp_ready = 1'b0;
                    done = 1;
                    break;
                end
                rs_cnt++;
            end
            @(negedge clk);
        end
        refill_ready = 1'b0;
        refill_done  = 1'b0;
        if (!done) r.timeout = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        if ({req_ready, resp_valid, refill_valid, resp_hit} !== 4'b0) begin
            $display("FAIL reset_ctrl: got %b expected 0000", {req_ready, resp_valid, refill_valid, resp_hit});
            fails++;
        end
        asserts++;
        if ({tag_wen, tag_wdata, refill_addr, resp_way} !== 62'b0) begin
            $display("FAIL reset_data: wen=%h wdata=%h raddr=%h way=%h expected all 0",
                     tag_wen, tag_wdata, refill_addr, resp_way);
            fails++;
        end
        asserts++;
        rst = 1'b0;
        #1;
        if (req_ready !== 1'b0) begin
            $display("FAIL reset_ready_pre_edge: got %b expected 0", req_ready);
            fails++;
        end
        asserts++;
        @(negedge clk);
        if (req_ready !== 1'b1) begin
            $display("FAIL reset_ready_post_edge: got %b expected 1", req_ready);
            fails++;
        end
        asserts++;
    endtask

    task automatic test_cold_miss();
        txn_t r;
        do_req(32'h0000_1234, 0, 0, r);
        if (r.timeout !== 1'b0) begin
            $display("FAIL cold_timeout: got %b expected 0", r.timeout); fails++;
        end
        asserts++;
        if (r.raddr !== 32'h0000_1220) begin
            $display("FAIL cold_refill_addr: got %h expected 00001220", r.raddr); fails++;
        end
        asserts++;
        if ({r.waddr, r.wen, r.wdata} !== {3'd1, 4'b0001, 24'h000012}) begin
            $display("FAIL cold_tag_write: got set=%0d wen=%b wdata=%h expected set=1 wen=0001 wdata=000012",
                     r.waddr, r.wen, r.wdata); fails++;
        end
        asserts++;
        if ({r.hit, r.way} !== 3'b0_00 || r.wen_cnt != 1) begin
            $display("FAIL cold_resp: got hit=%b way=%0d writes=%0d expected hit=0 way=0 writes=1",
                     r.hit, r.way, r.wen_cnt); fails++;
        end
        asserts++;
    endtask

    task automatic test_hit();
        txn_t r;
        do_req(32'h0000_1230, 0, 0, r);
        if (r.timeout !== 1'b0 || r.resp_cyc != 2) begin
            $display("FAIL hit_latency: got timeout=%b cycles=%0d expected timeout=0 cycles=2",
                     r.timeout, r.resp_cyc); fails++;
        end
        asserts++;
        if ({r.hit, r.way, r.saw_refill} !== 4'b1_00_0 || r.wen_cnt != 0) begin
            $display("FAIL hit_resp: got hit=%b way=%0d refill=%b writes=%0d expected hit=1 way=0 refill=0 writes=0",
                     r.hit, r.way, r.saw_refill, r.wen_cnt); fails++;
        end
        asserts++;
    endtask

    task automatic test_fill_replace();
        txn_t r;
        logic [1:0] exp_way [6];
        exp_way = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 6; i++) begin
            do_req({24'h000100 + 24'(i), 8'h60}, 0, 0, r);
            if (r.timeout || r.hit !== 1'b0 || r.way !== exp_way[i] || r.waddr !== 3'd3 ||
                r.wen !== (4'b1 << exp_way[i])) begin
                $display("FAIL fill_%0d: got timeout=%b hit=%b way=%0d set=%0d wen=%b expected hit=0 way=%0d set=3",
                         i, r.timeout, r.hit, r.way, r.waddr, r.wen, exp_way[i]); fails++;
            end
            asserts++;
        end
        exp_way = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
        for (int i = 0; i < 3; i++) begin
            do_req({24'h000104 + 24'(i) - 24'(i == 2 ? 4 : 0), 8'h60}, 0, 0, r);
            if (r.timeout || r.hit !== 1'b1 || r.way !== exp_way[i] || r.saw_refill) begin
                $display("FAIL fill_rehit_%0d: got timeout=%b hit=%b way=%0d refill=%b expected hit=1 way=%0d refill=0",
                         i, r.timeout, r.hit, r.way, r.saw_refill, exp_way[i]); fails++;
            end
            asserts++;
        end
    endtask

    task automatic test_backpressure();
        txn_t r;
        do_req(32'h0000_5540, 5, 3, r);
        if (r.timeout !== 1'b0 || r.unstable !== 1'b0) begin
            $display("FAIL bp_stable: got timeout=%b unstable=%b expected 0 0", r.timeout, r.unstable); fails++;
        end
        asserts++;
        if (r.rv_cycles != 6 || r.resp_cycles != 4) begin
            $display("FAIL bp_hold: got refill_cycles=%0d resp_cycles=%0d expected 6 4",
                     r.rv_cycles, r.resp_cycles); fails++;
        end
        asserts++;
        if (r.wen_cnt != 1 || r.raddr !== 32'h0000_5540 || r.hit !== 1'b0 || r.way !== 2'd0) begin
            $display("FAIL bp_result: got writes=%0d raddr=%h hit=%b way=%0d expected 1 00005540 0 0",
                     r.wen_cnt, r.raddr, r.hit, r.way); fails++;
        end
        asserts++;
    endtask

    task automatic test_invalidate();
        txn_t r;
        do_req(32'h0000_1230, 0, 0, r);
        if (r.hit !== 1'b1 || r.way !== 2'd0) begin
            $display("FAIL inv_prehit: got hit=%b way=%0d expected 1 0", r.hit, r.way); fails++;
        end
        asserts++;
        @(negedge clk);
        inv_all   = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_1230;
        #1;
        if (req_ready !== 1'b0) begin
            $display("FAIL inv_ready: got %b expected 0", req_ready); fails++;
        end
        asserts++;
        @(negedge clk);
        inv_all   = 1'b0;
        req_valid = 1'b0;
        do_req(32'h0000_1230, 0, 0, r);
        if (r.timeout || r.hit !== 1'b0 || r.way !== 2'd0 || r.wen !== 4'b0001) begin
            $display("FAIL inv_miss: got timeout=%b hit=%b way=%0d wen=%b expected 0 0 0 0001",
                     r.timeout, r.hit, r.way, r.wen); fails++;
        end
        asserts++;
    endtask

    task automatic test_reset_abort();
        txn_t r;
        int   wr_snap;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_7780;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        if (refill_valid !== 1'b1) begin
            $display("FAIL abort_refill_req: got %b expected 1", refill_valid); fails++;
        end
        asserts++;
        #2 rst = 1'b1;
        #1;
        if (refill_valid !== 1'b0) begin
            $display("FAIL abort_refill_drop: got %b expected 0", refill_valid); fails++;
        end
        asserts++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        if (req_ready !== 1'b1) begin
            $display("FAIL abort_ready_after_rst: got %b expected 1", req_ready); fails++;
        end
        asserts++;
        wr_snap   = wr_total;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        refill_ready = 1'b1;
        @(negedge clk);
        refill_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (tag_wen !== 4'b0) begin
                $display("FAIL abort_wen_%0d: got %b expected 0000", i, tag_wen); fails++;
            end
            asserts++;
        end
        rst = 1'b0;
        @(negedge clk);
        if (wr_total != wr_snap) begin
            $display("FAIL abort_no_write: got %0d writes expected %0d", wr_total, wr_snap); fails++;
        end
        asserts++;
        do_req(32'h0000_7780, 0, 0, r);
        if (r.timeout || r.hit !== 1'b0 || r.saw_refill !== 1'b1 || r.raddr !== 32'h0000_7780) begin
            $display("FAIL abort_relookup: got timeout=%b hit=%b refill=%b raddr=%h expected 0 0 1 00007780",
                     r.timeout, r.hit, r.saw_refill, r.raddr); fails++;
        end
        asserts++;
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_addr     = '0;
        resp_ready   = 1'b0;
        refill_ready = 1'b0;
        refill_done  = 1'b0;
        inv_all      = 1'b0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_fill_replace();
        test_backpressure();
        test_invalidate();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
